// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl -- hazard and debug-sequencing controller for a 5-stage pipeline
// (F, D, E, M, W).
//
// Functions:
//   * Operand forwarding selects for the instruction in E (from M or W).
//   * Load-use detection between E (load) and D (consumer), resolved with a
//     single bubble.
//   * Taken branch/jump flush of D and E.
//   * Data-memory wait: freezes the whole front of the pipe while M waits.
//   * Debug halt / single-step via a small FSM.
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | normal execution
//   MEMWAIT  | data memory busy in M; F/D/E/M frozen
//   HALT     | D held, E/M/W drain; waiting for step_req or halt_req release
//   STEP     | run until one instruction issues from D to E, then re-evaluate
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rs1D, rs2D              source indices of the instruction in D
//   rs1E, rs2E, rdE         source / destination indices in E
//   rdM, rdW                destination indices in M and W
//   regwriteE/M/W           register-write enables per stage
//   wbselE                  writeback select in E (00 = load)
//   pcselE                  taken branch/jump resolved in E
//   memreqM, dmem_ready     data-memory request in M and its completion
//   halt_req, step_req      debug halt level, single-step pulse
//   stallF/D/E/M            hold PC and D/E/M pipeline registers
//   flushD, flushE          clear D/E pipeline registers to a bubble
//   fwdAE, fwdBE            forward select (00 regfile, 01 W, 10 M)
//   halted                  high while the FSM is in HALT
//
// Build option:
//   PIPE_CTRL_PERF_EN       adds 32-bit wrapping counters stall_cnt (cycles
//                           with stallD) and flush_cnt (branch-caused flushE).
// ----------------------------------------------------------------------------
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  rdE,
    input  logic [4:0]  rdM,
    input  logic [4:0]  rdW,
    input  logic        regwriteE,
    input  logic        regwriteM,
    input  logic        regwriteW,
    input  logic [1:0]  wbselE,
    input  logic        pcselE,
    input  logic        memreqM,
    input  logic        dmem_ready,
    input  logic        halt_req,
    input  logic        step_req,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic [1:0]  fwdAE,
    output logic [1:0]  fwdBE,
    output logic        halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2,
        STEP    = 2'd3
    } state_t;

    state_t state;

    logic mem_wait;
    logic lu;
    logic br_flush;

    assign mem_wait = memreqM & ~dmem_ready;

    assign lu = regwriteE && (wbselE == 2'b00) && (rdE != 5'd0) &&
                ((rdE == rs1D) || (rdE == rs2D));

    // Forward select: M has priority over W because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (regwriteM && (rdM != 5'd0) && (rdM == rs))
            sel = 2'b10;
        else if (regwriteW && (rdW != 5'd0) && (rdW == rs))
            sel = 2'b01;
        return sel;
    endfunction

    // Stall/flush are purely combinational from state and inputs. The
    // exit cycle of MEMWAIT falls into the RUN/STEP branch, so it applies
    // normal run rules. Reset forces every output to zero.
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        br_flush = 1'b0;
        fwdAE    = 2'b00;
        fwdBE    = 2'b00;
        if (rst_n) begin
            fwdAE = fwd_sel(rs1E);
            fwdBE = fwd_sel(rs2E);
            if (mem_wait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end else if (state == HALT) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else if (pcselE) begin
                // Branch wins over load-use: the dependent instruction in D
                // is on the wrong path and is discarded anyway.
                flushD   = 1'b1;
                flushE   = 1'b1;
                br_flush = 1'b1;
            end else if (lu) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    // FSM with halted registered alongside the state so it tracks HALT exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (mem_wait) begin
            state  <= MEMWAIT;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req && !pcselE) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                MEMWAIT: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (step_req) begin
                        state  <= STEP;
                        halted <= 1'b0;
                    end else begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                STEP: begin
                    // One issue means D moved into E: no branch flush, no bubble.
                    if (!pcselE && !lu) begin
                        if (halt_req) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= RUN;
                            halted <= 1'b0;
                        end
                    end else begin
                        state  <= STEP;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stallD)
                stall_cnt <= stall_cnt + 32'd1;
            if (br_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regwriteE, regwriteM, regwriteW;
    logic [1:0]  wbselE;
    logic        pcselE, memreqM, dmem_ready, halt_req, step_req;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, halted;
    logic [1:0]  fwdAE, fwdBE;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rdM(rdM), .rdW(rdW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .wbselE(wbselE), .pcselE(pcselE), .memreqM(memreqM),
        .dmem_ready(dmem_ready), .halt_req(halt_req), .step_req(step_req),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .fwdAE(fwdAE), .fwdBE(fwdBE),
        .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {stallF,stallD,stallE,stallM,flushD,flushE,fwdAE,fwdBE,halted}
    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic [2:0] rw;      // {regwriteE, regwriteM, regwriteW}
        logic [1:0] wbselE;
        logic       pcselE, memreqM, dmem_ready;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[16];

    int n_cmp = 0;
    int n_err = 0;
    int issues = 0;
    bit counting = 0;

    function automatic logic [10:0] e(input logic [3:0] s, input logic [1:0] f,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic h);
        return {s, f, a, b, h};
    endfunction

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; wbselE = 2'b00;
        pcselE = 0; memreqM = 0; dmem_ready = 0;
    endtask

    // Push expectation, sample at the falling edge, pop and compare, then
    // step to just after the next rising edge.
    task automatic check(input string name, input logic [10:0] exp);
        sb_t ent;
        logic [10:0] got;
        sb.push_back('{name, exp});
        @(negedge clk);
        ent = sb.pop_front();
        got = {stallF, stallD, stallE, stallM, flushD, flushE, fwdAE, fwdBE, halted};
        n_cmp++;
        if (got !== ent.exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", ent.name, got, ent.exp);
        end
        if (counting && !got[9] && !got[5]) issues++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
        rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
        {regwriteE, regwriteM, regwriteW} = v.rw;
        wbselE = v.wbselE; pcselE = v.pcselE;
        memreqM = v.memreqM; dmem_ready = v.dmem_ready;
        halt_req = 0; step_req = 0;
        check(v.name, v.exp);
    endtask

    task automatic set_lu();
        rs1D = 5; rdE = 5; regwriteE = 1; wbselE = 2'b00;
    endtask

    logic [10:0] H;
    logic [10:0] Z;

    initial begin
        H = e(4'b1100, 2'b01, 2'b00, 2'b00, 1'b1);
        Z = 11'd0;
        //      name         rs1D rs2D rs1E rs2E rdE rdM rdW rw      wb     pc mr rdy exp
        vt[0]  = '{"idle",      1, 2, 3, 4, 7, 8, 9, 3'b000, 2'b00, 0, 0, 0, Z};
        vt[1]  = '{"fwd_m",     0, 0, 3, 7, 0, 3, 3, 3'b011, 2'b01, 0, 0, 0, e(4'b0000, 2'b00, 2'b10, 2'b00, 0)};
        vt[2]  = '{"fwd_w",     0, 0, 3, 7, 0, 0, 3, 3'b011, 2'b01, 0, 0, 0, e(4'b0000, 2'b00, 2'b01, 2'b00, 0)};
        vt[3]  = '{"fwd_mix",   0, 0, 4, 6, 0, 6, 4, 3'b011, 2'b01, 0, 0, 0, e(4'b0000, 2'b00, 2'b01, 2'b10, 0)};
        vt[4]  = '{"fwd_x0",    0, 0, 0, 0, 0, 0, 0, 3'b011, 2'b01, 0, 0, 0, Z};
        vt[5]  = '{"fwd_m_off", 0, 0, 3, 3, 0, 3, 3, 3'b001, 2'b01, 0, 0, 0, e(4'b0000, 2'b00, 2'b01, 2'b01, 0)};
        vt[6]  = '{"lu_rs1",    5, 1, 0, 0, 5, 0, 0, 3'b100, 2'b00, 0, 0, 0, e(4'b1100, 2'b01, 2'b00, 2'b00, 0)};
        vt[7]  = '{"lu_clear",  5, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, Z};
        vt[8]  = '{"lu_rs2",    2, 9, 0, 0, 9, 0, 0, 3'b100, 2'b00, 0, 0, 0, e(4'b1100, 2'b01, 2'b00, 2'b00, 0)};
        vt[9]  = '{"nolu_wb",   5, 5, 0, 0, 5, 0, 0, 3'b100, 2'b01, 0, 0, 0, Z};
        vt[10] = '{"nolu_x0",   0, 0, 0, 0, 0, 0, 0, 3'b100, 2'b00, 0, 0, 0, Z};
        vt[11] = '{"br_lu",     5, 0, 0, 0, 5, 0, 0, 3'b100, 2'b00, 1, 0, 0, e(4'b0000, 2'b11, 2'b00, 2'b00, 0)};
        vt[12] = '{"br",        0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 1, 0, 0, e(4'b0000, 2'b11, 2'b00, 2'b00, 0)};
        vt[13] = '{"memwait",   5, 0, 3, 0, 5, 3, 0, 3'b110, 2'b00, 1, 1, 0, e(4'b1111, 2'b00, 2'b10, 2'b00, 0)};
        vt[14] = '{"mem_exit",  5, 0, 0, 0, 5, 0, 0, 3'b100, 2'b00, 0, 1, 1, e(4'b1100, 2'b01, 2'b00, 2'b00, 0)};
        vt[15] = '{"idle2",     0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, Z};

        // Reset with hazard-causing inputs: everything must read zero.
        rst_n = 0; halt_req = 1; step_req = 0;
        clear_inputs();
        set_lu(); memreqM = 1; rs1E = 3; rdM = 3; regwriteM = 1;
        check("reset_a", Z);
        pcselE = 1; memreqM = 0;
        check("reset_b", Z);
        rst_n = 1; halt_req = 0; clear_inputs();

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        // Memory wait of four cycles, advance on the fifth.
        clear_inputs(); memreqM = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) check("mem4_wait", e(4'b1111, 2'b00, 2'b00, 2'b00, 0));
        dmem_ready = 1;
        check("mem4_advance", Z);
        memreqM = 0;
        check("mem4_after", Z);

        // Halt request blocked by a taken branch, then entry to HALT.
        halt_req = 1; pcselE = 1;
        check("halt_br_hold", e(4'b0000, 2'b11, 2'b00, 2'b00, 0));
        pcselE = 0;
        check("halt_enter", Z);
        counting = 1; issues = 0;
        check("halt_1", H);
        step_req = 1;
        check("halt_step1", H);
        step_req = 0;
        check("step1_issue", Z);
        check("halt_2", H);
        step_req = 1;
        check("halt_step2", H);
        step_req = 0; set_lu();
        check("step2_lu", e(4'b1100, 2'b01, 2'b00, 2'b00, 0));
        clear_inputs();
        check("step2_issue", Z);
        check("halt_3", H);
        counting = 0;
        n_cmp++;
        if (issues != 2) begin
            n_err++;
            $display("FAIL step_issue_count: got %0d required 2", issues);
        end
        halt_req = 0;
        check("halt_release", H);
        check("run_after_halt", Z);
        step_req = 1;
        check("step_ignored", Z);
        step_req = 0;
        check("run_still", Z);

        // Reset in the middle of MEMWAIT.
        memreqM = 1; dmem_ready = 0;
        check("pre_rst_mem", e(4'b1111, 2'b00, 2'b00, 2'b00, 0));
        rst_n = 0;
        check("rst_in_memwait", Z);
        rst_n = 1; clear_inputs();
        check("after_rst_mem", Z);

        // Reset in the middle of HALT; after release it must be RUN, not HALT.
        halt_req = 1;
        check("pre_halt", Z);
        check("in_halt", H);
        rst_n = 0;
        check("rst_in_halt", Z);
        rst_n = 1; halt_req = 0;
        check("after_rst_halt", Z);

`ifdef PIPE_CTRL_PERF_EN
        rst_n = 0;
        check("perf_reset", Z);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            clear_inputs(); set_lu();
            check("perf_lu", e(4'b1100, 2'b01, 2'b00, 2'b00, 0));
            clear_inputs();
            check("perf_idle", Z);
        end
        for (int i = 0; i < 2; i++) begin
            pcselE = 1;
            check("perf_br", e(4'b0000, 2'b11, 2'b00, 2'b00, 0));
            pcselE = 0;
            check("perf_idle2", Z);
        end
        n_cmp++;
        if (stall_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL stall_cnt: got %0d required 3", stall_cnt);
        end
        n_cmp++;
        if (flush_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d required 2", flush_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
